// File: rtl/dram_block_initiator.sv
// L2-side initiator for the block-to-subblock memory interface: serializes block writes into
// beats and reassembles strobe-tagged read beats into a full block.
module dram_block_initiator #(
   parameter int ADDR_BITS  = 32,
   parameter int BLOCK_BITS = 256,
   parameter int SUBBLOCKS  = 4,
   parameter int SUB_BITS   = BLOCK_BITS / SUBBLOCKS,
   parameter int STRB_BITS  = $clog2(SUBBLOCKS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_BITS-1:0]  req_addr,
   input  logic [BLOCK_BITS-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [BLOCK_BITS-1:0] rsp_rdata,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [STRB_BITS-1:0]  mem_din_strobe,
   output logic [SUB_BITS-1:0]   mem_din,
   input  logic [STRB_BITS-1:0]  mem_dout_strobe,
   input  logic [SUB_BITS-1:0]   mem_dout,
   input  logic                  mem_dready,
   input  logic                  mem_accR,
   input  logic                  mem_accW,
   output logic                  protocol_err,
   output logic                  busy
);

   localparam int OFFSET_BITS = $clog2(BLOCK_BITS / 8);
   localparam logic [ADDR_BITS-1:0] OFFSET_MASK = ADDR_BITS'((1 << OFFSET_BITS) - 1);

   typedef enum logic [2:0] {IDLE, WAIT_R, ISSUE_R, RECV, WAIT_W, SEND, RESP} state_t;

   state_t                state_q, state_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic                  we_q, we_d;
   logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
   logic [SUBBLOCKS-1:0]  mask_q, mask_d;
   logic [BLOCK_BITS-1:0] asm_q, asm_d;
   logic [STRB_BITS-1:0]  cnt_q, cnt_d;
   logic                  memEn_q, memEn_d;
   logic                  memWe_q, memWe_d;
   logic [STRB_BITS-1:0]  memStrb_q, memStrb_d;
   logic [SUB_BITS-1:0]   memDin_q, memDin_d;
   logic                  rspValid_q, rspValid_d;
   logic [BLOCK_BITS-1:0] rspData_q, rspData_d;
   logic                  err_q, err_d;

   // Next-state logic; every registered output is derived from the next state so that it
   // lines up exactly with the cycle the FSM spends in the corresponding state.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      asm_d      = asm_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      memEn_d    = 1'b0;
      memWe_d    = 1'b0;
      memStrb_d  = '0;
      memDin_d   = '0;
      rspValid_d = 1'b0;
      rspData_d  = rspData_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr & ~OFFSET_MASK;
               we_d    = req_we;
               wdata_d = req_wdata;
               mask_d  = '0;
               state_d = req_we ? WAIT_W : WAIT_R;
            end
         end
         WAIT_R: if (mem_accR) state_d = ISSUE_R;
         ISSUE_R: state_d = RECV;
         RECV: begin
            if (mem_dready) begin
               if (mask_q[mem_dout_strobe]) err_d = 1'b1;
               mask_d[mem_dout_strobe] = 1'b1;
               for (int i = 0; i < SUBBLOCKS; i++) begin
                  if (mem_dout_strobe == STRB_BITS'(i)) asm_d[i*SUB_BITS +: SUB_BITS] = mem_dout;
               end
               if (&mask_d) state_d = RESP;
            end
         end
         WAIT_W: begin
            if (mem_accW) begin
               state_d = SEND;
               cnt_d   = '0;
            end
         end
         SEND: begin
            cnt_d = cnt_q + STRB_BITS'(1);
            if (cnt_q == STRB_BITS'(SUBBLOCKS - 1)) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
            mask_d  = '0;
         end
         default: state_d = IDLE;
      endcase

      // Beats outside RECV are dropped but flagged.
      if (mem_dready && state_q != RECV) err_d = 1'b1;

      memEn_d = (state_d == ISSUE_R);
      memWe_d = (state_d == SEND);
      if (memWe_d) begin
         memStrb_d = cnt_d;
         for (int i = 0; i < SUBBLOCKS; i++) begin
            if (cnt_d == STRB_BITS'(i)) memDin_d = wdata_d[i*SUB_BITS +: SUB_BITS];
         end
      end
      rspValid_d = (state_d == RESP);
      if (rspValid_d) rspData_d = we_q ? wdata_q : asm_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         mask_q     <= '0;
         asm_q      <= '0;
         cnt_q      <= '0;
         memEn_q    <= 1'b0;
         memWe_q    <= 1'b0;
         memStrb_q  <= '0;
         memDin_q   <= '0;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         asm_q      <= asm_d;
         cnt_q      <= cnt_d;
         memEn_q    <= memEn_d;
         memWe_q    <= memWe_d;
         memStrb_q  <= memStrb_d;
         memDin_q   <= memDin_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
         err_q      <= err_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign mem_addr       = addr_q;
   assign mem_en         = memEn_q;
   assign mem_we         = memWe_q;
   assign mem_din_strobe = memStrb_q;
   assign mem_din        = memDin_q;
   assign rsp_valid      = rspValid_q;
   assign rsp_rdata      = rspData_q;
   assign protocol_err   = err_q;

endmodule
